// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch unit's control inputs, instruction-cache read port and
//   decode handshake into one interface.
//   master : the fetch unit side
//            (drives the cache read port, the dec_* head and buf_count)
//   slave  : the environment side
//            (drives the fetch control, the cache response and dec_ready)
// Signals
//   fetch_en, redirect_valid, redirect_pc   fetch control
//   ic_rd_dest, ic_rd_en, ic_nop            cache read request
//   ic_rd_out, ic_pc_out                    cache response (1-cycle latency)
//   dec_valid, dec_inst, dec_pc, dec_ready  decode valid/ready handshake
//   buf_count                               instruction buffer occupancy
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          fetch_en;
  logic          redirect_valid;
  logic [15:0]   redirect_pc;
  logic [15:0]   ic_rd_dest;
  logic          ic_rd_en;
  logic          ic_nop;
  logic [15:0]   ic_rd_out;
  logic [15:0]   ic_pc_out;
  logic          dec_valid;
  logic [15:0]   dec_inst;
  logic [15:0]   dec_pc;
  logic          dec_ready;
  logic [CW-1:0] buf_count;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, ic_rd_out, ic_pc_out, dec_ready,
    output ic_rd_dest, ic_rd_en, ic_nop, dec_valid, dec_inst, dec_pc, buf_count
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, ic_rd_out, ic_pc_out, dec_ready,
    input  ic_rd_dest, ic_rd_en, ic_nop, dec_valid, dec_inst, dec_pc, buf_count
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end sitting directly in front of the instruction
//   cache. It holds the PC, issues one cache read per cycle while the buffer
//   has credit, captures each 1-cycle-latency response into a small FIFO and
//   presents the FIFO head to decode over a valid/ready handshake.
//   A redirect reloads the PC and squashes both the outstanding read and
//   every buffered entry.
// Ports
//   clk  : clock, all state changes on posedge
//   rst  : asynchronous reset, active high
//   bus  : fetch_unit_if.master (fetch control, cache port, decode port,
//          buffer occupancy)
// Parameters
//   RESET_PC   : PC loaded on reset
//   FIFO_DEPTH : instruction buffer entries, power of two in 2..8
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [15:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [15:0]   inst_mem_q [FIFO_DEPTH];
  logic [15:0]   pc_mem_q   [FIFO_DEPTH];

  logic          dec_valid_w;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   credit_used;

  assign dec_valid_w = (count_q != '0);
  assign pop         = dec_valid_w & bus.dec_ready;

  // Entries already buffered plus the read still in the cache, minus the
  // entry leaving this cycle. Counting the pop lets a full-rate stream keep
  // issuing every cycle. One extra bit keeps the sum from overflowing.
  assign credit_used = {1'b0, count_q}
                     + {{CW{1'b0}}, inflight_q}
                     - {{CW{1'b0}}, pop};

  // The rst term keeps the read strobe low while reset is held.
  assign issue = bus.fetch_en & ~bus.redirect_valid & (credit_used < DEPTH_C) & ~rst;

  // A response arriving in a redirect cycle belongs to the squashed path.
  assign push = inflight_q & ~bus.redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) pc_d = pc_q + 16'd1;
      if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer entries are cleared on reset so the decode outputs read as zero
  // while reset is held.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        inst_mem_q[gi] <= '0;
        pc_mem_q[gi]   <= '0;
      end else if (push && (wr_ptr_q == PW'(gi))) begin
        inst_mem_q[gi] <= bus.ic_rd_out;
        pc_mem_q[gi]   <= bus.ic_pc_out;
      end
    end
  end

  assign bus.ic_rd_dest = pc_q;
  assign bus.ic_rd_en   = issue;
  assign bus.ic_nop     = bus.redirect_valid & ~rst;
  assign bus.dec_valid  = dec_valid_w;
  assign bus.dec_inst   = inst_mem_q[rd_ptr_q];
  assign bus.dec_pc     = pc_mem_q[rd_ptr_q];
  assign bus.buf_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit through a behavioural 1-cycle-latency cache. Expected
//   fetch PCs are queued when a fetch stream is started or redirected and are
//   popped whenever decode accepts an instruction.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] exp_q [$];

  fetch_unit_if #(.FIFO_DEPTH(DEPTH)) ifc ();

  fetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Cache contents are a fixed scramble of the address.
  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Cache model: one cycle latency, nop forces zero data.
  always @(posedge clk) begin
    ifc.ic_pc_out <= ifc.ic_rd_dest;
    ifc.ic_rd_out <= ifc.ic_nop ? 16'h0000 : inst_of(ifc.ic_rd_dest);
  end

  task automatic restart_stream(input logic [15:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(16'(base + 16'(i)));
  endtask

  task automatic test_reset;
    logic [15:0] e;
    ifc.fetch_en       = 1'b1;
    ifc.dec_ready      = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 16'h1234;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ifc.ic_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b, required 0", ifc.ic_rd_en); end
    n_cmp++; if (ifc.ic_nop !== 1'b0) begin n_err++; $display("FAIL rst_nop: got %b, required 0", ifc.ic_nop); end
    n_cmp++; if (ifc.dec_valid !== 1'b0) begin n_err++; $display("FAIL rst_dec_valid: got %b, required 0", ifc.dec_valid); end
    n_cmp++; if (ifc.buf_count !== 2'd0) begin n_err++; $display("FAIL rst_buf_count: got %0d, required 0", ifc.buf_count); end
    n_cmp++; if (ifc.ic_rd_dest !== 16'h0000) begin n_err++; $display("FAIL rst_rd_dest: got %h, required 0000", ifc.ic_rd_dest); end
    n_cmp++; if (ifc.dec_inst !== 16'h0000) begin n_err++; $display("FAIL rst_dec_inst: got %h, required 0000", ifc.dec_inst); end
    ifc.redirect_valid = 1'b0;
    e = 16'h0;
  endtask

  task automatic test_stream;
    logic [15:0] e;
    restart_stream(16'h0000);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 0) rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (ifc.ic_rd_en !== 1'b1 || ifc.ic_rd_dest !== 16'(c)) begin
        n_err++; $display("FAIL stream_issue c%0d: got en=%b dest=%h, required en=1 dest=%h", c, ifc.ic_rd_en, ifc.ic_rd_dest, 16'(c)); end
      n_cmp++; if (ifc.dec_valid !== (c >= 2)) begin
        n_err++; $display("FAIL stream_valid c%0d: got %b, required %b", c, ifc.dec_valid, (c >= 2)); end
      if (ifc.dec_valid === 1'b1 && ifc.dec_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL stream_extra: got pc=%h, required none", ifc.dec_pc); end
        else begin
          e = exp_q.pop_front();
          if (ifc.dec_pc !== e || ifc.dec_inst !== inst_of(e)) begin n_err++;
            $display("FAIL stream_data: got pc=%h inst=%h, required pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst, e, inst_of(e)); end
          else $display("txn stream pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] e;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      ifc.dec_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (ifc.ic_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en c%0d: got %b, required 0", c, ifc.ic_rd_en); end
      if (c >= 1) begin
        n_cmp++; if (ifc.buf_count !== 2'd2) begin n_err++; $display("FAIL bp_count c%0d: got %0d, required 2", c, ifc.buf_count); end
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      ifc.dec_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (ifc.dec_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %b, required 1", c, ifc.dec_valid); end
      if (ifc.dec_valid === 1'b1 && ifc.dec_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_extra: got pc=%h, required none", ifc.dec_pc); end
        else begin
          e = exp_q.pop_front();
          if (ifc.dec_pc !== e || ifc.dec_inst !== inst_of(e)) begin n_err++;
            $display("FAIL bp_data: got pc=%h inst=%h, required pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst, e, inst_of(e)); end
          else $display("txn bp pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst);
        end
      end
    end
  endtask

  task automatic test_redirect_full;
    logic [15:0] e;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      ifc.dec_ready = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (ifc.buf_count !== 2'd2) begin n_err++; $display("FAIL rf_full: got %0d, required 2", ifc.buf_count); end
    @(posedge clk); #1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 16'h0040;
    @(negedge clk);
    n_cmp++; if (ifc.ic_nop !== 1'b1) begin n_err++; $display("FAIL rf_nop: got %b, required 1", ifc.ic_nop); end
    n_cmp++; if (ifc.ic_rd_en !== 1'b0) begin n_err++; $display("FAIL rf_rd_en: got %b, required 0", ifc.ic_rd_en); end
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      ifc.redirect_valid = 1'b0;
      ifc.dec_ready      = 1'b1;
      if (k == 1) restart_stream(16'h0040);
      @(negedge clk);
      if (k == 1) begin
        n_cmp++; if (ifc.buf_count !== 2'd0) begin n_err++; $display("FAIL rf_flush: got %0d, required 0", ifc.buf_count); end
        n_cmp++; if (ifc.ic_rd_en !== 1'b1 || ifc.ic_rd_dest !== 16'h0040) begin n_err++;
          $display("FAIL rf_issue: got en=%b dest=%h, required en=1 dest=0040", ifc.ic_rd_en, ifc.ic_rd_dest); end
      end
      if (k <= 3) begin
        n_cmp++; if (ifc.dec_valid !== (k == 3)) begin n_err++; $display("FAIL rf_valid N+%0d: got %b, required %b", k, ifc.dec_valid, (k == 3)); end
      end
      if (ifc.dec_valid === 1'b1 && ifc.dec_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rf_extra: got pc=%h, required none", ifc.dec_pc); end
        else begin
          e = exp_q.pop_front();
          if (ifc.dec_pc !== e || ifc.dec_inst !== inst_of(e)) begin n_err++;
            $display("FAIL rf_data: got pc=%h inst=%h, required pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst, e, inst_of(e)); end
          else $display("txn rf pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst);
        end
      end
    end
  endtask

  task automatic test_redirect_wrap;
    logic [15:0] e;
    logic [15:0] wrap_tbl [4];
    wrap_tbl = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      ifc.redirect_valid = (k == 0);
      ifc.redirect_pc    = 16'hFFFE;
      if (k == 1) restart_stream(16'hFFFE);
      @(negedge clk);
      if (k == 3) begin
        n_cmp++; if (ifc.ic_rd_dest !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got %h, required 0000", ifc.ic_rd_dest); end
      end
      if (k >= 3 && k <= 6) begin
        n_cmp++; if (ifc.dec_valid !== 1'b1 || ifc.dec_pc !== wrap_tbl[k-3]) begin n_err++;
          $display("FAIL wrap_seq N+%0d: got v=%b pc=%h, required v=1 pc=%h", k, ifc.dec_valid, ifc.dec_pc, wrap_tbl[k-3]); end
      end
      // A handshake in the redirect cycle itself still consumes the old head.
      if (ifc.dec_valid === 1'b1 && ifc.dec_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL wrap_extra: got pc=%h, required none", ifc.dec_pc); end
        else begin
          e = exp_q.pop_front();
          if (ifc.dec_pc !== e || ifc.dec_inst !== inst_of(e)) begin n_err++;
            $display("FAIL wrap_data: got pc=%h inst=%h, required pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst, e, inst_of(e)); end
          else $display("txn wrap pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst);
        end
      end
    end
  endtask

  task automatic test_fetch_disable;
    logic [15:0] e;
    int npop = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      ifc.fetch_en  = 1'b0;
      ifc.dec_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (ifc.ic_rd_en !== 1'b0) begin n_err++; $display("FAIL dis_rd_en c%0d: got %b, required 0", c, ifc.ic_rd_en); end
      n_cmp++; if (ifc.buf_count !== ((c == 0) ? 2'd1 : 2'd2)) begin n_err++;
        $display("FAIL dis_count c%0d: got %0d, required %0d", c, ifc.buf_count, (c == 0) ? 1 : 2); end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      ifc.dec_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (ifc.ic_rd_en !== 1'b0) begin n_err++; $display("FAIL dis_drain_rd_en c%0d: got %b, required 0", c, ifc.ic_rd_en); end
      if (ifc.dec_valid === 1'b1 && ifc.dec_ready === 1'b1) begin
        npop++;
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL dis_extra: got pc=%h, required none", ifc.dec_pc); end
        else begin
          e = exp_q.pop_front();
          if (ifc.dec_pc !== e || ifc.dec_inst !== inst_of(e)) begin n_err++;
            $display("FAIL dis_data: got pc=%h inst=%h, required pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst, e, inst_of(e)); end
          else $display("txn dis pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst);
        end
      end
    end
    n_cmp++; if (npop != 2) begin n_err++; $display("FAIL dis_pops: got %0d, required 2", npop); end
    n_cmp++; if (ifc.dec_valid !== 1'b0 || ifc.buf_count !== 2'd0) begin n_err++;
      $display("FAIL dis_empty: got v=%b count=%0d, required v=0 count=0", ifc.dec_valid, ifc.buf_count); end
  endtask

  task automatic test_reset_midstream;
    logic [15:0] e;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      ifc.fetch_en  = 1'b1;
      ifc.dec_ready = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (ifc.buf_count !== 2'd2) begin n_err++; $display("FAIL mr_fill: got %0d, required 2", ifc.buf_count); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (ifc.dec_valid !== 1'b0 || ifc.buf_count !== 2'd0) begin n_err++;
      $display("FAIL mr_clear: got v=%b count=%0d, required v=0 count=0", ifc.dec_valid, ifc.buf_count); end
    n_cmp++; if (ifc.ic_rd_en !== 1'b0 || ifc.ic_rd_dest !== 16'h0000) begin n_err++;
      $display("FAIL mr_port: got en=%b dest=%h, required en=0 dest=0000", ifc.ic_rd_en, ifc.ic_rd_dest); end
    ifc.dec_ready = 1'b1;
    restart_stream(16'h0000);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (ifc.ic_rd_dest !== 16'(c)) begin n_err++; $display("FAIL mr_dest c%0d: got %h, required %h", c, ifc.ic_rd_dest, 16'(c)); end
      n_cmp++; if (ifc.dec_valid !== (c >= 2)) begin n_err++; $display("FAIL mr_valid c%0d: got %b, required %b", c, ifc.dec_valid, (c >= 2)); end
      if (ifc.dec_valid === 1'b1 && ifc.dec_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL mr_extra: got pc=%h, required none", ifc.dec_pc); end
        else begin
          e = exp_q.pop_front();
          if (ifc.dec_pc !== e || ifc.dec_inst !== inst_of(e)) begin n_err++;
            $display("FAIL mr_data: got pc=%h inst=%h, required pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst, e, inst_of(e)); end
          else $display("txn mr pc=%h inst=%h", ifc.dec_pc, ifc.dec_inst);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_wrap();
    test_fetch_disable();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
